// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Single-cycle RV32 integer ALU with registered outputs.
//                Operand B is chosen from rs2, the I-type immediate, the
//                S-type immediate or zero. Performs add/sub, bitwise logic,
//                shifts, signed/unsigned compares, branch-condition
//                evaluation and JALR target generation. All three outputs
//                are captured on the rising edge of clk, one op per cycle.
//
//  Ports       : clk    - rising-edge clock
//                rst    - synchronous active-high reset (clears all outputs)
//                rs1    - operand A
//                rs2    - register operand B candidate
//                immi   - sign-extended I-type immediate
//                imms   - sign-extended S-type immediate
//                aluop  - operation code
//                irmux  - operand B select (00 rs2, 01 immi, 10 imms, 11 zero)
//                result - registered ALU result
//                jt     - registered JALR jump target
//                bt     - registered branch-taken flag
//
//  Config      : ALU_BRANCH_EXT_EN - when defined, BNE, SLTU, BLT and BGE
//                are implemented; otherwise those codes behave as NOP.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] immi,
    input  logic [31:0] imms,
    input  logic [3:0]  aluop,
    input  logic [1:0]  irmux,
    output logic [31:0] result,
    output logic [31:0] jt,
    output logic        bt
);

    // ------------------------------------------------------------------------
    // Operation codes
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_SLL  = 4'b0101;
    localparam logic [3:0] c_OP_SRL  = 4'b0110;
    localparam logic [3:0] c_OP_SRA  = 4'b0111;
    localparam logic [3:0] c_OP_BEQ  = 4'b1000;
    localparam logic [3:0] c_OP_BNE  = 4'b1001;
    localparam logic [3:0] c_OP_SLT  = 4'b1010;
    localparam logic [3:0] c_OP_SLTU = 4'b1011;
    localparam logic [3:0] c_OP_BLT  = 4'b1100;
    localparam logic [3:0] c_OP_BGE  = 4'b1101;
    localparam logic [3:0] c_OP_JALR = 4'b1110;

    // Operand B select encodings
    localparam logic [1:0] c_SEL_RS2  = 2'b00;
    localparam logic [1:0] c_SEL_IMMI = 2'b01;
    localparam logic [1:0] c_SEL_IMMS = 2'b10;

    // JALR clears bit 0 of the computed target
    localparam logic [31:0] c_JALR_MASK = 32'hFFFF_FFFE;

    // ------------------------------------------------------------------------
    // Operand B selection
    // ------------------------------------------------------------------------
    logic [31:0] w_opb;
    logic [4:0]  w_shamt;

    always_comb begin
        w_opb = 32'd0;
        case (irmux)
            c_SEL_RS2:  w_opb = rs2;
            c_SEL_IMMI: w_opb = immi;
            c_SEL_IMMS: w_opb = imms;
            default:    w_opb = 32'd0;
        endcase
    end

    assign w_shamt = w_opb[4:0];

    // ------------------------------------------------------------------------
    // Shared datapath terms
    // ------------------------------------------------------------------------
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;
    logic [31:0] w_jalr_sum;
    logic        w_eq;
    logic        w_lt_s;
    logic        w_lt_u;

    assign w_sum      = rs1 + w_opb;
    assign w_diff     = rs1 - w_opb;
    assign w_sll      = rs1 << w_shamt;
    assign w_srl      = rs1 >> w_shamt;
    assign w_sra      = $unsigned($signed(rs1) >>> w_shamt);
    // JALR always pairs rs1 with the I-type immediate, independent of irmux
    assign w_jalr_sum = rs1 + immi;
    assign w_eq       = (rs1 == w_opb);
    assign w_lt_s     = ($signed(rs1) < $signed(w_opb));
    assign w_lt_u     = (rs1 < w_opb);

    // ------------------------------------------------------------------------
    // Next-output decode. Every output defaults to zero so that branch ops
    // leave result at 0, non-branch ops leave bt at 0 and only JALR drives jt.
    // ------------------------------------------------------------------------
    logic [31:0] w_result;
    logic [31:0] w_jt;
    logic        w_bt;

    always_comb begin
        w_result = 32'd0;
        w_jt     = 32'd0;
        w_bt     = 1'b0;
        case (aluop)
            c_OP_ADD:  w_result = w_sum;
            c_OP_SUB:  w_result = w_diff;
            c_OP_AND:  w_result = rs1 & w_opb;
            c_OP_OR:   w_result = rs1 | w_opb;
            c_OP_XOR:  w_result = rs1 ^ w_opb;
            c_OP_SLL:  w_result = w_sll;
            c_OP_SRL:  w_result = w_srl;
            c_OP_SRA:  w_result = w_sra;
            c_OP_BEQ:  w_bt     = w_eq;
            c_OP_SLT:  w_result = {31'd0, w_lt_s};
            c_OP_JALR: w_jt     = w_jalr_sum & c_JALR_MASK;
`ifdef ALU_BRANCH_EXT_EN
            c_OP_BNE:  w_bt     = ~w_eq;
            c_OP_SLTU: w_result = {31'd0, w_lt_u};
            c_OP_BLT:  w_bt     = w_lt_s;
            c_OP_BGE:  w_bt     = ~w_lt_s;
`else
            // Extension codes fall through to the all-zero NOP behaviour
            c_OP_BNE, c_OP_SLTU, c_OP_BLT, c_OP_BGE: begin
                w_result = 32'd0;
                w_jt     = 32'd0;
                w_bt     = 1'b0;
            end
`endif
            default: begin
                w_result = 32'd0;
                w_jt     = 32'd0;
                w_bt     = 1'b0;
            end
        endcase
    end

`ifndef ALU_BRANCH_EXT_EN
    // Unsigned compare is only consumed by SLTU; keep it referenced so the
    // reduced build carries no dangling logic warnings.
    logic w_unused_ltu;
    assign w_unused_ltu = w_lt_u;
`endif

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    logic [31:0] r_result;
    logic [31:0] r_jt;
    logic        r_bt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 32'd0;
            r_jt     <= 32'd0;
            r_bt     <= 1'b0;
        end else begin
            r_result <= w_result;
            r_jt     <= w_jt;
            r_bt     <= w_bt;
        end
    end

    assign result = r_result;
    assign jt     = r_jt;
    assign bt     = r_bt;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu
//  Description : Self-checking bench for alu. A table of directed vectors
//                with hand-computed results is applied one per cycle, plus
//                short sequences for reset, reset release and output hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] immi;
    logic [31:0] imms;
    logic [3:0]  aluop;
    logic [1:0]  irmux;
    logic [31:0] result;
    logic [31:0] jt;
    logic        bt;

`ifdef ALU_BRANCH_EXT_EN
    localparam bit c_EXT = 1'b1;
`else
    localparam bit c_EXT = 1'b0;
`endif

    alu u_dut (
        .clk    (clk),
        .rst    (rst),
        .rs1    (rs1),
        .rs2    (rs2),
        .immi   (immi),
        .imms   (imms),
        .aluop  (aluop),
        .irmux  (irmux),
        .result (result),
        .jt     (jt),
        .bt     (bt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  irmux;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] immi;
        logic [31:0] imms;
        logic [31:0] exp_result;
        logic [31:0] exp_jt;
        logic        exp_bt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    task automatic check32(input string name, input int idx,
                           input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic check1(input string name, input int idx,
                          input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0b expected %0b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ii, input logic [31:0] is);
        aluop = op;
        irmux = sel;
        rs1   = a;
        rs2   = b;
        immi  = ii;
        imms  = is;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // op, irmux, rs1, rs2, immi, imms, result, jt, bt
        vecs.push_back('{4'b0000, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, 32'd30,        32'd0, 1'b0}); // ADD
        vecs.push_back('{4'b0001, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, 32'hFFFF_FFF6, 32'd0, 1'b0}); // SUB
        vecs.push_back('{4'b0010, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0,         32'd0, 1'b0}); // AND
        vecs.push_back('{4'b0011, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, 32'h1E,        32'd0, 1'b0}); // OR
        vecs.push_back('{4'b0100, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, 32'h1E,        32'd0, 1'b0}); // XOR
        vecs.push_back('{4'b0101, 2'b01, 32'd10, 32'd0,  32'd5, 32'd0, 32'h140,       32'd0, 1'b0}); // SLL
        vecs.push_back('{4'b0110, 2'b01, 32'd10, 32'd0,  32'd5, 32'd0, 32'd0,         32'd0, 1'b0}); // SRL
        vecs.push_back('{4'b0111, 2'b01, 32'd10, 32'd0,  32'd5, 32'd0, 32'd0,         32'd0, 1'b0}); // SRA
        vecs.push_back('{4'b0111, 2'b01, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 32'hF800_0000, 32'd0, 1'b0}); // SRA sign fill
        vecs.push_back('{4'b0110, 2'b01, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 32'h0800_0000, 32'd0, 1'b0}); // SRL zero fill
        vecs.push_back('{4'b0101, 2'b00, 32'd1,  32'h25, 32'd0, 32'd0, 32'h20,        32'd0, 1'b0}); // SLL uses B[4:0]
        vecs.push_back('{4'b1000, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0,         32'd0, 1'b0}); // BEQ ne
        vecs.push_back('{4'b1000, 2'b00, 32'd10, 32'd10, 32'd0, 32'd0, 32'd0,         32'd0, 1'b1}); // BEQ eq
        vecs.push_back('{4'b1010, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, 32'd1,         32'd0, 1'b0}); // SLT
        vecs.push_back('{4'b1010, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1,   32'd0, 1'b0}); // SLT -1<1
        vecs.push_back('{4'b1011, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0,   32'd0, 1'b0}); // SLTU -1 vs 1
        vecs.push_back('{4'b1011, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, {31'd0, c_EXT}, 32'd0, 1'b0}); // SLTU 10<20
        vecs.push_back('{4'b1001, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0,         32'd0, c_EXT}); // BNE
        vecs.push_back('{4'b1001, 2'b00, 32'd10, 32'd10, 32'd0, 32'd0, 32'd0,         32'd0, 1'b0});  // BNE eq
        vecs.push_back('{4'b1100, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0,         32'd0, c_EXT}); // BLT
        vecs.push_back('{4'b1100, 2'b00, 32'd1,  32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0,  32'd0, 1'b0});  // BLT 1 < -1 false
        vecs.push_back('{4'b1101, 2'b00, 32'd20, 32'd10, 32'd0, 32'd0, 32'd0,         32'd0, c_EXT}); // BGE
        vecs.push_back('{4'b1101, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0,   32'd0, 1'b0});  // BGE -1>=1 false
        vecs.push_back('{4'b1111, 2'b00, 32'd10, 32'd20, 32'd5, 32'd7, 32'd0,         32'd0, 1'b0}); // NOP
        vecs.push_back('{4'b0000, 2'b01, 32'd10, 32'd20, 32'd5, 32'd0, 32'd15,        32'd0, 1'b0}); // ADDI
        vecs.push_back('{4'b0000, 2'b10, 32'd10, 32'd20, 32'd5, 32'd15, 32'd25,       32'd0, 1'b0}); // ADD imms
        vecs.push_back('{4'b0000, 2'b11, 32'd10, 32'd20, 32'd5, 32'd15, 32'd10,       32'd0, 1'b0}); // ADD zero
        vecs.push_back('{4'b0000, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0,   32'd0, 1'b0}); // ADD wrap
        vecs.push_back('{4'b1110, 2'b00, 32'h101, 32'd20, 32'd4, 32'd0, 32'd0,        32'h104, 1'b0}); // JALR
        vecs.push_back('{4'b1110, 2'b10, 32'h100, 32'd0,  32'd3, 32'd8, 32'd0,        32'h102, 1'b0}); // JALR ignores irmux

        // Reset state
        rst = 1'b1;
        drive(4'b0000, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check32("reset_result", 0, result, 32'd0);
        check32("reset_jt",     0, jt,     32'd0);
        check1 ("reset_bt",     0, bt,     1'b0);

        // Reset released: next edge captures the pending ADD
        rst = 1'b0;
        @(posedge clk);
        #1;
        check32("release_add", 0, result, 32'd30);

        // Reset overrides an operation issued in the same cycle
        drive(4'b1110, 2'b00, 32'h101, 32'd0, 32'd4, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check32("rst_ovr_result", 0, result, 32'd0);
        check32("rst_ovr_jt",     0, jt,     32'd0);
        drive(4'b0000, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        check32("rst_hold_add", 0, result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check32("post_rst_add", 0, result, 32'd30);

        // Outputs hold between edges while inputs change
        drive(4'b0001, 2'b00, 32'd99, 32'd1, 32'd0, 32'd0);
        #2;
        check32("hold_result", 0, result, 32'd30);

        // Table vectors, back to back, one per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].irmux, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].immi, vecs[i].imms);
            @(posedge clk);
            #1;
            check32("vec_result", i, result, vecs[i].exp_result);
            check32("vec_jt",     i, jt,     vecs[i].exp_jt);
            check1 ("vec_bt",     i, bt,     vecs[i].exp_bt);
        end

        // Branch flag drops on the following non-branch op
        drive(4'b1000, 2'b00, 32'd7, 32'd7, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        check1("beq_set", 0, bt, 1'b1);
        drive(4'b0011, 2'b00, 32'd7, 32'd7, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        check1 ("bt_clear",  0, bt,     1'b0);
        check32("or_result", 0, result, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu.md
# alu

Single-cycle RV32 integer ALU for the processor datapath, between register-file/immediate-generator and writeback/PC-select logic. Selects operand B from rs2 or an immediate and performs arithmetic, logic, shift, compare or branch-condition evaluation per `aluop`. Also produces a JALR jump target. Results are registered once per clock.

## Interface
- No parameters; datapath width fixed at 32 bits.
- Clocking: one clock; reset is synchronous and active-high.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous active-high reset.
- `rs1` input 32: operand A.
- `rs2` input 32: register operand B candidate.
- `immi` input 32: sign-extended I-type immediate.
- `imms` input 32: sign-extended S-type immediate.
- `aluop` input 4: operation code.
- `irmux` input 2: operand-B select; 00 = rs2, 01 = immi, 10 = imms, 11 = 32'd0.
- `result` output 32: registered ALU result.
- `jt` output 32: registered jump target.
- `bt` output 1: registered branch-taken flag.

## Operation
- B = irmux-selected operand; shamt = B[4:0].
- aluop codes:
  - 0000 ADD: result = rs1 + B, mod 2^32.
  - 0001 SUB: result = rs1 − B, two's complement.
  - 0010 AND, 0011 OR, 0100 XOR: bitwise.
  - 0101 SLL: rs1 << shamt.
  - 0110 SRL: logical right shift by shamt.
  - 0111 SRA: arithmetic right shift by shamt, sign-filled from rs1[31].
  - 1000 BEQ: bt = (rs1 == B).
  - 1001 BNE: bt = (rs1 != B).
  - 1010 SLT: result = {31'b0, signed(rs1) < signed(B)}.
  - 1011 SLTU: result = {31'b0, rs1 < B unsigned}.
  - 1100 BLT: bt = signed(rs1) < signed(B).
  - 1101 BGE: bt = signed(rs1) >= signed(B).
  - 1110 JALR: jt = (rs1 + immi) & 32'hFFFF_FFFE; result = 0.
  - 1111 NOP: all outputs 0.
- Defaults for every code: result = 0 for branch ops; bt = 0 for non-branch ops; jt = 0 except JALR.
- JALR uses immi regardless of irmux.
- No overflow or carry flags; wrap-around is silent.

## Timing
- Outputs are registered: inputs presented before a rising edge appear on result/jt/bt after that edge. Latency is 1 cycle; throughput is one op per cycle.
- No handshake; a new operation is accepted every cycle.
- rst high at a rising edge: result = 0, jt = 0, bt = 0. Reset overrides any operation issued that cycle.
- Release of reset: the next edge captures the current inputs normally.
- Outputs hold their value between edges even if inputs change.

## Configuration
- `ALU_BRANCH_EXT_EN` defined: BNE (1001), SLTU (1011), BLT (1100) and BGE (1101) are implemented as above.
- Undefined: those four codes behave exactly as NOP (all outputs 0).
- ADD through SRA, BEQ, SLT, JALR and NOP are always present.

## Test plan
- rs1 = 10, rs2 = 20, irmux = 00, sweep 0000–0100 → after one edge: ADD 30, SUB 0xFFFFFFF6 (−10), AND 0, OR 0x1E, XOR 0x1E.
- rs1 = 10, immi = 5, irmux = 01: SLL → 0x140, SRL → 0, SRA → 0; rs1 = 0x80000000, SRA by 4 → 0xF8000000.
- Compare ops with rs1 = 10, rs2 = 20, irmux = 00:
  - BEQ → bt = 0; rs2 = 10 → bt = 1.
  - SLT → result = 1.
  - rs1 = −1 vs rs2 = 1: SLT → 1, SLTU → 0 (macro on).
- NOP → result = 0, bt = 0, jt = 0; ADDI (0000, irmux = 01, rs1 = 10, immi = 5) → result = 15; irmux = 10, imms = 15 → 25.
- JALR: rs1 = 0x101, immi = 4 → jt = 0x104, result = 0.
- rst asserted while ADD is issued → all outputs 0 at that edge; deassert → correct result one edge later. Without the macro, BLT → bt = 0.
